// File: rtl/mac_unit_param.sv
// Purpose : iterative multiply-accumulate; BPC multiplier bits retired per cycle, signed guarded accumulator.
// Latency : XLEN/BPC + 1 cycles from the start accept edge to the acc_valid pulse.
// Backpr. : no handshake; start_mul is only sampled in IDLE, so starts while busy are dropped.
//
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   rs1, rs2               multiplicand / multiplier, with per-operand signed flags
//   sub_mode               0: acc += product, 1: acc -= product
//   start_mul, clear_acc   start request (IDLE only); clear + abort
//   mac_result             signed accumulator, ACC_W = 2*XLEN+ACC_GUARD bits
//   acc_valid              one-cycle pulse when mac_result was just updated
//   acc_busy               operation in flight
//   acc_ovf                sticky overflow (saturation or wrap)
module mac_unit_param #(
  parameter int XLEN      = 32,
  parameter int BPC       = 4,
  parameter int ACC_GUARD = 8,
  parameter int SATURATE  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [XLEN-1:0]                     rs1,
  input  logic [XLEN-1:0]                     rs2,
  input  logic                                rs1_signed,
  input  logic                                rs2_signed,
  input  logic                                sub_mode,
  input  logic                                start_mul,
  input  logic                                clear_acc,
  output logic signed [2*XLEN+ACC_GUARD-1:0]  mac_result,
  output logic                                acc_valid,
  output logic                                acc_busy,
  output logic                                acc_ovf
);

  localparam int ACC_W = 2*XLEN + ACC_GUARD;
  localparam int PW    = 2*XLEN;             // unsigned product magnitude width
  localparam int EW    = ACC_W + 2;          // accumulate width, never overflows
  localparam int N     = XLEN / BPC;         // MUL cycles
  localparam int CW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_e;

  state_e             state_q;
  logic [PW-1:0]      a_sh_q;     // |a| shifted to the weight of the current digit
  logic [XLEN-1:0]    b_q;        // remaining digits of |b|, consumed LSB first
  logic               neg_q;
  logic               sub_q;
  logic [PW-1:0]      prod_q;
  logic [CW-1:0]      cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic               vld_q;
  logic               ovf_q;

  logic               a_neg, b_neg;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic [PW-1:0]      part;
  logic [PW-1:0]      prod_d;
  logic [PW:0]        p_mag, p_sgn;
  logic [EW-1:0]      p_ext, acc_ext, sum;
  logic               ovf_now;
  logic [ACC_W-1:0]   acc_d;

  always_comb begin
    a_neg   = rs1_signed & rs1[XLEN-1];
    b_neg   = rs2_signed & rs2[XLEN-1];
    a_mag   = a_neg ? -rs1 : rs1;
    b_mag   = b_neg ? -rs2 : rs2;

    part    = a_sh_q * {{(PW-BPC){1'b0}}, b_q[BPC-1:0]};
    prod_d  = prod_q + part;

    // One extra bit so an unsigned*unsigned maximum product stays positive.
    p_mag   = {1'b0, prod_q};
    p_sgn   = neg_q ? -p_mag : p_mag;
    p_ext   = {{(EW-PW-1){p_sgn[PW]}}, p_sgn};
    acc_ext = {{2{acc_q[ACC_W-1]}}, acc_q};
    sum     = sub_q ? (acc_ext - p_ext) : (acc_ext + p_ext);

    // In range iff the bits above the ACC_W sign bit all match it.
    ovf_now = (sum[EW-1:ACC_W-1] != 3'b000) && (sum[EW-1:ACC_W-1] != 3'b111);

    acc_d   = sum[ACC_W-1:0];
    if (ovf_now && (SATURATE != 0)) begin
      acc_d = sum[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      sub_q   <= 1'b0;
      prod_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (clear_acc) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          // A start is still accepted alongside a clear; it then accumulates onto 0.
          if (start_mul) begin
            a_sh_q  <= {{XLEN{1'b0}}, a_mag};
            b_q     <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            sub_q   <= sub_mode;
            prod_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (clear_acc) begin
            state_q <= S_IDLE;
          end else begin
            prod_q <= prod_d;
            a_sh_q <= a_sh_q << BPC;
            b_q    <= b_q >> BPC;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(N-1)) begin
              state_q <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (!clear_acc) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | ovf_now;
            vld_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mac_result = acc_q;
  assign acc_valid  = vld_q;
  assign acc_busy   = (state_q != S_IDLE);
  assign acc_ovf    = ovf_q;

endmodule

// File: doc/mac_unit_param.md
Name: mac_unit_param

Overview:
- Parametrised, iterative multiply-accumulate unit. Next generation of the existing 32-bit MAC, used in the ALU MAC path.
- Adds configurable operand width and radix, guard bits, add/subtract mode, optional saturation and a sticky overflow flag.
- Multiplier is sequential (BPC bits per cycle) to save area. The accumulator is a signed register of ACC_W = 2*XLEN+ACC_GUARD bits.

Parameters:
- XLEN, 32, operand width. Must be a multiple of BPC.
- BPC, 4, multiplier bits retired per cycle. Allowed values: 1, 2, 4, 8.
- ACC_GUARD, 8, extra accumulator guard bits above 2*XLEN.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk, input, 1, clock. All logic on the rising edge.
- rst, input, 1, synchronous active-low reset: the design resets on the rising clk edge when rst==0.
- rs1, input, XLEN, multiplicand.
- rs2, input, XLEN, multiplier.
- rs1_signed, input, 1, rs1 is two's complement.
- rs2_signed, input, 1, rs2 is two's complement.
- sub_mode, input, 1, 0: acc += product; 1: acc -= product.
- start_mul, input, 1, start request. Sampled only in IDLE.
- clear_acc, input, 1, zero the accumulator and flags. Aborts any in-flight operation.
- mac_result, output, ACC_W, signed accumulator value.
- acc_valid, output, 1, one-cycle pulse: mac_result was just updated.
- acc_busy, output, 1, an operation is in flight.
- acc_ovf, output, 1, sticky overflow (saturation or wrap occurred).

Behaviour:
- Reset (rst==0 at an edge):
  - State goes to IDLE.
  - mac_result=0, acc_valid=0, acc_busy=0, acc_ovf=0.
  - All internal registers cleared.
  - Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, ACC.
- IDLE:
  - On start_mul=1, latch rs1, rs2, both signed flags and sub_mode.
  - Form the magnitudes |a|, |b| and neg = sign(a) XOR sign(b). A negative value only exists when its signed flag is set.
  - Clear the partial product and go to MUL.
- MUL:
  - Each cycle adds |a| * (next BPC bits of |b|, LSB first), shifted into place.
  - Runs N = XLEN/BPC cycles, then goes to ACC.
- ACC:
  - p = neg ? -P : P, sign-extended to 2*XLEN+1 bits. This width is required: an unsigned*unsigned max product does not fit in 2*XLEN signed bits.
  - Compute acc ± p at ACC_W+2 bits.
  - If the result is outside the signed ACC_W range:
    - SATURATE=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
    - SATURATE=0: truncate.
    - In both cases set acc_ovf=1. It stays set until clear_acc or reset.
  - Register the result into mac_result, pulse acc_valid for one cycle, return to IDLE.
- Timing: the start accept edge is edge k. acc_busy=1 from edge k to edge k+N+1. At edge k+N+1, mac_result updates, acc_valid=1 and acc_busy=0. Latency is N+1 cycles (9 at the defaults).
- Back-to-back: start_mul may be asserted in the same cycle acc_valid is high, and is accepted at the next edge.
- start_mul while busy (MUL or ACC) is ignored. No queueing; the latched operands are unaffected.
- clear_acc:
  - Highest priority after reset. At that edge: mac_result=0, acc_ovf=0, acc_valid=0, acc_busy=0, state goes to IDLE.
  - Any in-flight product is discarded.
  - clear_acc and start_mul together in IDLE: the clear applies and the start is also accepted. The new product accumulates onto 0.
- Operand changes after the accept edge have no effect.
- mac_result holds its value between updates.

Test Plan:
- Defaults. Reset, then rs1=3, rs2=0xFFFFFFFB, both signed, start -> after 9 cycles acc_valid pulses once, mac_result=-15 (0xFF_FFFF_FFFF_FFFF_FFF1), acc_busy high for exactly 9 cycles, acc_ovf=0.
- clear_acc, then rs1=rs2=0xFFFFFFFF unsigned -> mac_result=0x00_FFFF_FFFE_0000_0001. Next, rs1=0x7FFFFFFF unsigned, rs2=0x80000000 signed, accumulated onto 0 after clear -> mac_result=0xFF_C000_0000_8000_0000.
- Accumulate 10*10 (add), then 10*10 with sub_mode=1 -> mac_result 100, then 0. A start_mul pulsed during the second operation's MUL is ignored: exactly one acc_valid and the final value is 0.
- ACC_GUARD=0, SATURATE=1: 0xFFFFFFFF * 0xFFFFFFFF unsigned -> mac_result=0x7FFF_FFFF_FFFF_FFFF, acc_ovf=1. Repeat with SATURATE=0 -> mac_result=0xFFFF_FFFE_0000_0001, acc_ovf=1.
- Start 5*7 with acc=20, assert clear_acc at MUL cycle 3 -> next cycle mac_result=0, acc_busy=0, and no acc_valid ever appears for the aborted operation. Assert rst=0 mid-MUL -> all outputs 0 at that edge.
- BPC=1 and BPC=8 builds: 0x12345678 * 0x9ABCDEF0 unsigned -> mac_result=0x0B00_EA4E_242D_2080, with latency 33 and 5 cycles respectively.
